// File: rtl/sync_debounce_edge_pkg.sv
// Shared types for the debounce/edge-detect block: FSM state encoding.
package sync_debounce_edge_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'b00,
        S_CHK_HIGH = 2'b01,
        S_HIGH     = 2'b11,
        S_CHK_LOW  = 2'b10
    } db_state_t;

endpackage

// File: rtl/sync_debounce_edge_if.sv
// Signal bundle between the synchronizer side (master) and the debouncer (slave).
interface sync_debounce_edge_if #(
    parameter int CNT_W = 8
);
    logic             sig_syn;
    logic             cnt_clr;
    logic             level_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] press_cnt;

    modport master (
        output sig_syn,
        output cnt_clr,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  press_cnt
    );

    modport slave (
        input  sig_syn,
        input  cnt_clr,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output press_cnt
    );
endinterface

// File: rtl/sync_debounce_edge.sv
// Debounces a synchronized level, emits one-cycle rise/fall pulses and counts accepted rises.
// Latency: change accepted DEBOUNCE_CYCLES-1 edges after it is first sampled; all outputs registered.
// Backpressure: none; the input is sampled every cycle and the outputs are always valid.
module sync_debounce_edge
    import sync_debounce_edge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sync_debounce_edge_if.slave  dbi
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    db_state_t        state_q, state_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic             level_q, level_nxt;
    logic             rise_q, rise_nxt;
    logic             fall_q, fall_nxt;
    logic [CNT_W-1:0] press_q, press_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            level_q <= level_nxt;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
            press_q <= press_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        level_nxt = level_q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        press_nxt = press_q;

        case (state_q)
            S_LOW: begin
                if (dbi.sig_syn) begin
                    state_nxt = S_CHK_HIGH;
                    cnt_nxt   = CW'(1);
                end
            end
            S_CHK_HIGH: begin
                if (!dbi.sig_syn) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else if (cnt_q == LAST) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                    press_nxt = press_q + CNT_W'(1);
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            S_HIGH: begin
                if (!dbi.sig_syn) begin
                    state_nxt = S_CHK_LOW;
                    cnt_nxt   = CW'(1);
                end
            end
            S_CHK_LOW: begin
                if (dbi.sig_syn) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt_q == LAST) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
            end
        endcase

        // Clear wins over a same-edge increment: that rise goes uncounted.
        if (dbi.cnt_clr) begin
            press_nxt = '0;
        end
    end

    assign dbi.level_out  = level_q;
    assign dbi.rise_pulse = rise_q;
    assign dbi.fall_pulse = fall_q;
    assign dbi.press_cnt  = press_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Self-checking bench for sync_debounce_edge: vector table, directed corner sequences, random vs run-length model.
module tb_sync_debounce_edge;

    localparam int D  = 4;
    localparam int CW = 4;

    logic clk;
    logic rst_n;

    sync_debounce_edge_if #(.CNT_W(CW)) dbi ();

    sync_debounce_edge #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbi   (dbi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: accepted level plus the length of the current run of
    // samples that disagree with it; a run of D flips the level.
    logic m_level, m_rise, m_fall;
    int   m_run, m_cnt;

    typedef struct {
        logic     sig;
        logic     clr;
        logic     level;
        logic     rise;
        logic     fall;
        int       cnt;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic s, input logic c);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_level) m_run++;
        else m_run = 0;
        if (m_run == D) begin
            m_level = s;
            m_run   = 0;
            if (s) begin
                m_rise = 1'b1;
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end else begin
                m_fall = 1'b1;
            end
        end
        if (c) m_cnt = 0;
    endtask

    task automatic tick(input logic s, input logic c);
        dbi.sig_syn = s;
        dbi.cnt_clr = c;
        @(posedge clk);
        model_edge(s, c);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".level"}, int'(dbi.level_out), int'(m_level));
        chk({tag, ".rise"},  int'(dbi.rise_pulse), int'(m_rise));
        chk({tag, ".fall"},  int'(dbi.fall_pulse), int'(m_fall));
        chk({tag, ".cnt"},   int'(dbi.press_cnt), m_cnt);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".level"}, int'(dbi.level_out), 0);
        chk({tag, ".rise"},  int'(dbi.rise_pulse), 0);
        chk({tag, ".fall"},  int'(dbi.fall_pulse), 0);
        chk({tag, ".cnt"},   int'(dbi.press_cnt), 0);
    endtask

    // Async reset asserted and released between edges; outputs checked before the next edge.
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1 chk_zero(tag);
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   rises;
        int   hold;
        logic lvl;

        rst_n       = 1'b0;
        dbi.sig_syn = 1'b0;
        dbi.cnt_clr = 1'b0;
        model_reset();
        #3 chk_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_zero("reset_hold");
        #2 rst_n = 1'b1;

        // {sig, clr} -> expected {level, rise, fall, press_cnt} after the edge
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0});

        foreach (vecs[i]) begin
            tick(vecs[i].sig, vecs[i].clr);
            chk($sformatf("vec%0d.level", i), int'(dbi.level_out), int'(vecs[i].level));
            chk($sformatf("vec%0d.rise", i),  int'(dbi.rise_pulse), int'(vecs[i].rise));
            chk($sformatf("vec%0d.fall", i),  int'(dbi.fall_pulse), int'(vecs[i].fall));
            chk($sformatf("vec%0d.cnt", i),   int'(dbi.press_cnt), vecs[i].cnt);
        end

        // Wrap: 16 accepted rises walk press_cnt 1..15 then 0 (starting from 0, level high).
        for (int k = 1; k <= 16; k++) begin
            for (int j = 0; j < D; j++) begin tick(1'b0, 1'b0); chk_model("wrap_lo"); end
            for (int j = 0; j < D; j++) begin tick(1'b1, 1'b0); chk_model("wrap_hi"); end
            chk("wrap.rise", int'(dbi.rise_pulse), 1);
            chk("wrap.cnt", int'(dbi.press_cnt), k % 16);
        end

        // Async reset in the middle of a falling check, then a rise 4 edges after release.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("pre_reset.level", int'(dbi.level_out), 1);
        async_reset("midchk");
        dbi.sig_syn = 1'b1;
        for (int j = 1; j <= D; j++) begin
            tick(1'b1, 1'b0);
            chk($sformatf("post_reset%0d.rise", j), int'(dbi.rise_pulse), (j == D) ? 1 : 0);
            chk($sformatf("post_reset%0d.level", j), int'(dbi.level_out), (j == D) ? 1 : 0);
        end

        // Bouncing: from a low level, toggle every 2 cycles for 40 cycles then settle high.
        async_reset("bounce_start");
        rises = 0;
        for (int j = 0; j < 40; j++) begin
            tick(((j / 2) % 2) == 0, 1'b0);
            chk_model("bounce");
            rises += int'(dbi.rise_pulse);
        end
        for (int j = 1; j <= D + 2; j++) begin
            tick(1'b1, 1'b0);
            chk($sformatf("settle%0d.rise", j), int'(dbi.rise_pulse), (j == D) ? 1 : 0);
            rises += int'(dbi.rise_pulse);
        end
        chk("bounce.rises", rises, 1);

        // Random runs of varying length with occasional clears and resets.
        hold = 0;
        lvl  = 1'b0;
        for (int j = 0; j < 2000; j++) begin
            if (hold == 0) begin
                lvl  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 7);
            end
            hold--;
            tick(lvl, $urandom_range(0, 15) == 0);
            chk_model("rand");
            if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sync_debounce_edge.md
Name: sync_debounce_edge

Overview:
- Downstream consumer of the 3-flop input synchronizer; takes its already-synchronized output `sig_syn`.
- Debounces the level: a change is accepted only after it is stable for DEBOUNCE_CYCLES consecutive clocks.
- Produces a clean level, single-cycle rise/fall pulses and a wrapping rise counter.
- Feeds push-button / switch handling logic in the lab designs.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable samples needed to accept a level change; legal range 2..65535.
- CNT_W, 8, width of press_cnt.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sig_syn  input  1  synchronized raw level from the synchronizer stage.
- cnt_clr  input  1  synchronous clear of press_cnt.
- level_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse on an accepted 0->1 change.
- fall_pulse  output  1  one-cycle pulse on an accepted 1->0 change.
- press_cnt  output  CNT_W  count of accepted rises, modulo 2^CNT_W.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset, asserted at any time including mid-debounce:
  - Immediately: level_out=0, rise_pulse=0, fall_pulse=0, press_cnt=0.
  - Internal: state=S_LOW, stability counter=0.
  - Release: takes effect on the first posedge with rst_n=1.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW.
  - S_LOW: sig_syn=1 -> S_CHK_HIGH, cnt<=1. Otherwise stay.
  - S_CHK_HIGH, sig_syn=0: -> S_LOW, cnt<=0. No output change.
  - S_CHK_HIGH, sig_syn=1 and cnt==DEBOUNCE_CYCLES-1: -> S_HIGH, level_out<=1, rise_pulse<=1, cnt<=0.
  - S_CHK_HIGH, sig_syn=1 otherwise: cnt<=cnt+1.
  - S_HIGH: sig_syn=0 -> S_CHK_LOW, cnt<=1. Otherwise stay.
  - S_CHK_LOW: mirror of S_CHK_HIGH with inverted sig_syn; on acceptance -> S_LOW, level_out<=0, fall_pulse<=1.
- Latency:
  - If sig_syn is first sampled high at edge k and stays high, level_out and rise_pulse go high after edge k+DEBOUNCE_CYCLES-1.
  - rise_pulse is high for exactly one cycle, coincident with the first cycle of level_out=1.
  - Falling direction is symmetric.
- Glitch rejection: any reversal during a CHK state restarts from the stable state. Glitches shorter than DEBOUNCE_CYCLES produce no output activity.
- rise_pulse and fall_pulse are mutually exclusive and never asserted on consecutive cycles. The minimum spacing between them is DEBOUNCE_CYCLES.
- Stability counter width: clog2(DEBOUNCE_CYCLES)+1. It never exceeds DEBOUNCE_CYCLES-1.
- press_cnt:
  - Increments on the same edge that sets rise_pulse.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - cnt_clr=1 clears it to 0 on the next edge.
  - cnt_clr has priority over a simultaneous increment: result is 0 and that rise is not counted.
- Unused state encodings: return to S_LOW and clear the stability counter on the next edge.

Decomposition:
- Shared package holds the state type/encoding (S_LOW=2'b00, S_CHK_HIGH=2'b01, S_HIGH=2'b11, S_CHK_LOW=2'b10).
- No sub-module. FSM, stability counter and press counter fit in one module; a separate counter block would only add wiring.
- Top-level integration instantiates the synchronizer, then this block.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=4):
1. Clean rise: sig_syn 0->1 first sampled at edge 10, held -> level_out=1 and rise_pulse=1 after edge 13. rise_pulse=0 after edge 14. press_cnt=1.
2. Glitch: sig_syn high for 3 sampled cycles, then low -> level_out stays 0, no pulses, press_cnt unchanged, FSM back in S_LOW.
3. Clean fall from S_HIGH: sig_syn low from edge 20 -> level_out=0 and fall_pulse=1 after edge 23, for one cycle only. press_cnt unchanged.
4. Wrap and clear:
   - 16 accepted rises -> press_cnt sequence 1..15 then 0.
   - cnt_clr asserted on the accepting edge of a rise -> press_cnt=0 and rise_pulse still 1.
5. Async reset: rst_n dropped mid-S_CHK_LOW between edges -> outputs 0 before the next edge. After release with sig_syn=1, a rise is accepted 4 edges later.
6. Bouncing input: sig_syn toggles every 2 cycles for 40 cycles, then settles high -> exactly one rise_pulse, 4 edges after settling.
